// File: rtl/bch_pkg.sv
// rtl/bch_pkg.sv - shared widths and FSM encoding for the BCH coefficient-ROM reader
package bch_pkg;

   localparam int BCH_W  = 192;
   localparam int BCH_N  = 24;
   localparam int BCH_AW = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } bch_state_e;

endpackage

// File: rtl/gf2_dot_w.sv
// rtl/gf2_dot_w.sv - GF(2) dot product of one ROM row with the BCH state
module gf2_dot_w
   import bch_pkg::*;
#(
   parameter int W = BCH_W
) (
   input  logic [W-1:0] row,
   input  logic [W-1:0] state,
   output logic         dot
);

   assign dot = ^(row & state);

endmodule

// File: rtl/bch_matvec_reader.sv
// rtl/bch_matvec_reader.sv - walks one coefficient ROM and builds an N-bit next-state slice
module bch_matvec_reader
   import bch_pkg::*;
#(
   parameter int W  = BCH_W,
   parameter int N  = BCH_N,
   parameter int AW = BCH_AW
) (
   input  logic          clk_1x,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_state,
   output logic          rom_rd_en,
   output logic [AW-1:0] rom_rdaddr,
   input  logic [W-1:0]  rom_rd_q,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_result
);

   localparam logic [1:0]    S_IDLE    = IDLE;
   localparam logic [1:0]    S_RUN     = RUN;
   localparam logic [1:0]    S_DRAIN   = DRAIN;
   localparam logic [1:0]    S_DONE    = DONE;
   localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

   logic [1:0]    fsm;
   logic [AW-1:0] addr;
   logic [AW-1:0] pend_idx;
   logic          pend;
   logic [W-1:0]  state_reg;
   logic [N-1:0]  result;
   logic          row_dot;
   logic          accept;

   // in_ready is gated by rst_n so it reads 0 for the whole reset window
   assign in_ready   = rst_n && (fsm == S_IDLE);
   assign accept     = in_valid && in_ready;
   assign rom_rd_en  = (fsm == S_RUN);
   assign rom_rdaddr = addr;
   assign out_valid  = (fsm == S_DONE);
   assign out_result = result;

   gf2_dot_w #(.W(W)) u_dot (
      .row   (rom_rd_q),
      .state (state_reg),
      .dot   (row_dot)
   );

   always_ff @(posedge clk_1x or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= S_IDLE;
         addr      <= '0;
         state_reg <= '0;
      end else begin
         case (fsm)
            S_IDLE: begin
               if (accept) begin
                  state_reg <= in_state;
                  addr      <= '0;
                  fsm       <= S_RUN;
               end
            end
            S_RUN: begin
               // addr parks at the last row; it is cleared only on the next accept
               if (addr == LAST_ADDR) begin
                  fsm <= S_DRAIN;
               end else begin
                  addr <= addr + 1'b1;
               end
            end
            S_DRAIN: fsm <= S_DONE;
            default: begin
               if (out_ready) begin
                  fsm <= S_IDLE;
               end
            end
         endcase
      end
   end

   // The ROM port has one cycle of latency, so the row index travels alongside it
   always_ff @(posedge clk_1x or negedge rst_n) begin
      if (!rst_n) begin
         pend     <= 1'b0;
         pend_idx <= '0;
      end else begin
         pend     <= (fsm == S_RUN);
         pend_idx <= addr;
      end
   end

   always_ff @(posedge clk_1x or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
      end else if (accept) begin
         result <= '0;
      end else if (pend) begin
         result[pend_idx] <= row_dot;
      end
   end

endmodule

// File: tb/tb_bch_matvec_reader.sv
// tb/tb_bch_matvec_reader.sv - self-checking bench for bch_matvec_reader
module tb_bch_matvec_reader;

   localparam int W  = 192;
   localparam int N  = 24;
   localparam int AW = 5;

   logic          clk_1x = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_state;
   logic          rom_rd_en;
   logic [AW-1:0] rom_rdaddr;
   logic [W-1:0]  rom_rd_q;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_result;

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] rom [N];

   typedef struct {
      int           rom_kind;
      logic [W-1:0] st;
      logic [N-1:0] exp;
   } vec_t;

   vec_t vecs [5];

   bch_matvec_reader dut (
      .clk_1x     (clk_1x),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_state   (in_state),
      .rom_rd_en  (rom_rd_en),
      .rom_rdaddr (rom_rdaddr),
      .rom_rd_q   (rom_rd_q),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result)
   );

   always #5 clk_1x = ~clk_1x;

   // Registered ROM; garbage on the data bus whenever no read is issued
   always @(posedge clk_1x) begin
      if (rom_rd_en) rom_rd_q <= rom[rom_rdaddr];
      else           rom_rd_q <= {6{$urandom}};
   end

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] v;
      for (int i = 0; i < 6; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [N-1:0] model(input logic [W-1:0] st);
      logic [N-1:0] r;
      int ones;
      for (int k = 0; k < N; k++) begin
         ones = 0;
         for (int b = 0; b < W; b++) if (rom[k][b] && st[b]) ones++;
         r[k] = (ones % 2) == 1;
      end
      return r;
   endfunction

   task automatic load_rom(input int kind);
      for (int k = 0; k < N; k++) begin
         case (kind)
            0:       rom[k] = '0;
            1:       rom[k] = W'(1) << k;
            2:       rom[k] = '1;
            default: rom[k] = rand_w();
         endcase
      end
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_ready(output bit ok);
      int n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk_1x);
         n++;
      end
      ok = (in_ready === 1'b1);
      check("wait_in_ready", 32'(ok), 32'd1);
   endtask

   task automatic run_txn(input string nm, input logic [W-1:0] st, input logic [N-1:0] exp,
                          input int hold, input bit glitch);
      bit ok;
      int bad;
      wait_ready(ok);
      if (!ok) return;
      in_valid = 1'b1;
      in_state = st;
      @(negedge clk_1x);
      in_valid = 1'b0;
      bad = 0;
      for (int k = 0; k < N; k++) begin
         if (rom_rd_en !== 1'b1 || rom_rdaddr !== AW'(k)) bad++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
         if (glitch && k == 5) begin
            in_valid = 1'b1;
            in_state = ~st;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk_1x);
      end
      in_valid = 1'b0;
      check({nm, "_rdseq_errors"}, 32'(bad), 32'd0);
      check({nm, "_drain_quiet"}, {30'd0, rom_rd_en, out_valid}, 32'd0);
      @(negedge clk_1x);
      check({nm, "_out_valid"}, 32'(out_valid), 32'd1);
      check({nm, "_out_result"}, 32'(out_result), 32'(exp));
      bad = 0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk_1x);
         if (out_result !== exp || out_valid !== 1'b1 || in_ready !== 1'b0 || rom_rd_en !== 1'b0)
            bad++;
      end
      check({nm, "_hold_errors"}, 32'(bad), 32'd0);
      out_ready = 1'b1;
      @(negedge clk_1x);
      out_ready = 1'b0;
      check({nm, "_back_to_idle"}, {30'd0, in_ready, out_valid}, 32'h2);
   endtask

   initial begin
      logic [W-1:0] st;
      bit ok;
      vecs[0] = '{0, {W{1'b1}}, 24'h000000};
      vecs[1] = '{1, 192'hFFFFFF, 24'hFFFFFF};
      vecs[2] = '{1, 192'h000001, 24'h000001};
      vecs[3] = '{2, 192'h7, 24'hFFFFFF};
      vecs[4] = '{2, (W'(1) << 191) | 192'h7, 24'h000000};

      rst_n = 1'b0;
      in_valid = 1'b0;
      in_state = '0;
      out_ready = 1'b0;
      load_rom(0);
      repeat (3) @(negedge clk_1x);
      check("reset_in_ready", 32'(in_ready), 32'd0);
      check("reset_rd", {26'd0, rom_rd_en, rom_rdaddr}, 32'd0);
      check("reset_out", {7'd0, out_valid, out_result}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("post_reset_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk_1x);

      for (int i = 0; i < 5; i++) begin
         load_rom(vecs[i].rom_kind);
         run_txn($sformatf("vec%0d", i), vecs[i].st, vecs[i].exp, 0, 1'b0);
      end

      for (int i = 0; i < 6; i++) begin
         load_rom(3);
         st = rand_w();
         run_txn($sformatf("rand%0d", i), st, model(st), (i == 0) ? 10 : int'($urandom_range(0, 3)), 1'b0);
      end

      load_rom(3);
      st = rand_w();
      run_txn("glitch", st, model(st), 2, 1'b1);

      // Reset in the middle of a walk
      wait_ready(ok);
      in_valid = 1'b1;
      in_state = rand_w();
      @(negedge clk_1x);
      in_valid = 1'b0;
      repeat (9) @(negedge clk_1x);
      check("midrun_was_reading", 32'(rom_rd_en), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrun_reset_outputs", {29'd0, rom_rd_en, out_valid, in_ready}, 32'd0);
      check("midrun_reset_result", 32'(out_result), 32'd0);
      @(negedge clk_1x);
      rst_n = 1'b1;
      @(negedge clk_1x);
      check("after_reset_idle", {30'd0, in_ready, out_valid}, 32'h2);
      st = rand_w();
      run_txn("after_reset", st, model(st), 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
